// File: rtl/rtc_scheduler.sv
// rtc_scheduler: shares the RTC write/read engines between a set-time request and a poll tick,
// walking NREG consecutive registers per request. Optional watchdog: define RTC_SCHED_TIMEOUT_EN.
module rtc_scheduler #(
  parameter int         NREG     = 6,
  parameter logic [7:0] BASE_DIR = 8'h21,
  parameter int         TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       wr_req,
  output logic       wr_ack,
  output logic [2:0] wr_idx,
  input  logic [7:0] wr_val,
  output logic       wr_go,
  output logic [7:0] wr_dir,
  output logic [7:0] wr_dato,
  input  logic       wr_done,
  output logic       rd_go,
  output logic [7:0] rd_dir,
  input  logic       rd_done,
  input  logic [7:0] rd_dato,
  output logic       t_valid,
  output logic [2:0] t_idx,
  output logic [7:0] t_data,
  output logic       busy,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, WR_RUN, WR_GAP, RD_RUN, RD_GAP} state_t;
  localparam logic [2:0] LAST_IDX = 3'(NREG - 1);

  state_t     state_reg;
  logic [2:0] idx_reg;
  logic       last_reg;
  logic       poll_pend_reg;
  logic       wr_armed_reg;
  logic       wr_ack_reg, wr_go_reg, rd_go_reg, t_valid_reg;
  logic [7:0] wr_dir_reg, wr_dato_reg, rd_dir_reg, t_data_reg;
  logic [2:0] t_idx_reg;
  logic       timeout;
  logic       wr_start;
  logic       is_last;
  logic [7:0] dir_next;

  assign dir_next = BASE_DIR + {5'd0, idx_reg};
  assign wr_start = wr_req && wr_armed_reg;
  assign is_last  = (idx_reg == LAST_IDX);

  // idx advances on the done edge, so during the gap wr_idx already names the next
  // register and wr_val for it is ready to be captured when RUN is re-entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      idx_reg       <= 3'd0;
      last_reg      <= 1'b0;
      poll_pend_reg <= 1'b0;
      wr_armed_reg  <= 1'b0;
      wr_ack_reg    <= 1'b0;
      wr_go_reg     <= 1'b0;
      rd_go_reg     <= 1'b0;
      t_valid_reg   <= 1'b0;
      wr_dir_reg    <= 8'd0;
      wr_dato_reg   <= 8'd0;
      rd_dir_reg    <= 8'd0;
      t_data_reg    <= 8'd0;
      t_idx_reg     <= 3'd0;
    end else begin
      wr_ack_reg  <= 1'b0;
      t_valid_reg <= 1'b0;
      if (tick)
        poll_pend_reg <= 1'b1;
      if (!wr_req)
        wr_armed_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (wr_start) begin
            state_reg   <= WR_RUN;
            wr_go_reg   <= 1'b1;
            wr_dir_reg  <= dir_next;
            wr_dato_reg <= wr_val;
          end else if (poll_pend_reg || tick) begin
            poll_pend_reg <= 1'b0;
            state_reg     <= RD_RUN;
            rd_go_reg     <= 1'b1;
            rd_dir_reg    <= dir_next;
          end
        end
        WR_RUN: begin
          if (wr_done || timeout) begin
            wr_go_reg <= 1'b0;
            state_reg <= WR_GAP;
            last_reg  <= is_last;
            if (is_last) begin
              wr_ack_reg   <= 1'b1;
              wr_armed_reg <= 1'b0;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end
        end
        WR_GAP: begin
          if (last_reg) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            last_reg  <= 1'b0;
          end else begin
            state_reg   <= WR_RUN;
            wr_go_reg   <= 1'b1;
            wr_dir_reg  <= dir_next;
            wr_dato_reg <= wr_val;
          end
        end
        RD_RUN: begin
          if (rd_done || timeout) begin
            rd_go_reg <= 1'b0;
            state_reg <= RD_GAP;
            last_reg  <= is_last;
            if (rd_done) begin
              t_valid_reg <= 1'b1;
              t_data_reg  <= rd_dato;
              t_idx_reg   <= idx_reg;
            end
            if (!is_last)
              idx_reg <= idx_reg + 3'd1;
          end
        end
        RD_GAP: begin
          if (last_reg) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            last_reg  <= 1'b0;
          end else begin
            state_reg  <= RD_RUN;
            rd_go_reg  <= 1'b1;
            rd_dir_reg <= dir_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_reg;
  logic          err_reg;
  logic          in_run;
  logic          run_done;

  assign in_run   = (state_reg == WR_RUN) || (state_reg == RD_RUN);
  assign run_done = (state_reg == WR_RUN) ? wr_done : rd_done;
  // Fires on the TIMEOUT-th RUN cycle; the FSM treats it exactly like a done.
  assign timeout  = in_run && !run_done && (cnt_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= (in_run && !run_done && !timeout) ? cnt_reg + CW'(1) : '0;
      if (timeout)
        err_reg <= 1'b1;
    end
  end
  assign err = err_reg;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign wr_ack  = wr_ack_reg;
  assign wr_idx  = idx_reg;
  assign wr_go   = wr_go_reg;
  assign wr_dir  = wr_dir_reg;
  assign wr_dato = wr_dato_reg;
  assign rd_go   = rd_go_reg;
  assign rd_dir  = rd_dir_reg;
  assign t_valid = t_valid_reg;
  assign t_idx   = t_idx_reg;
  assign t_data  = t_data_reg;
  assign busy    = (state_reg != IDLE);
endmodule

// File: tb/tb_rtc_scheduler.sv
// Directed bench for rtc_scheduler with simple write/read engine models (done 4 cycles after go).
module tb_rtc_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       wr_req = 1'b0;
  logic       wr_ack, wr_go, wr_done, rd_go, rd_done, t_valid, busy, err;
  logic [2:0] wr_idx, t_idx;
  logic [7:0] wr_val, wr_dir, wr_dato, rd_dir, rd_dato, t_data;

  always #5 clk = ~clk;

  rtc_scheduler #(.NREG(6), .BASE_DIR(8'h21), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .tick(tick), .wr_req(wr_req), .wr_ack(wr_ack),
    .wr_idx(wr_idx), .wr_val(wr_val), .wr_go(wr_go), .wr_dir(wr_dir),
    .wr_dato(wr_dato), .wr_done(wr_done), .rd_go(rd_go), .rd_dir(rd_dir),
    .rd_done(rd_done), .rd_dato(rd_dato), .t_valid(t_valid), .t_idx(t_idx),
    .t_data(t_data), .busy(busy), .err(err)
  );

  assign wr_val = 8'h10 + {5'd0, wr_idx};

  // Engine models: self-reset on low go, one-cycle done on the 4th go cycle.
  int         wcnt, rcnt;
  logic [7:0] silent_dir = 8'h00;
  always @(posedge clk) begin
    if (!wr_go) begin
      wcnt <= 0; wr_done <= 1'b0;
    end else begin
      wcnt <= wcnt + 1; wr_done <= (wcnt == 3) && (wr_dir != silent_dir);
    end
  end
  always @(posedge clk) begin
    if (!rd_go) begin
      rcnt <= 0; rd_done <= 1'b0;
    end else begin
      rcnt <= rcnt + 1; rd_done <= (rcnt == 3);
      if (rcnt == 3) rd_dato <= 8'h30 + (rd_dir - 8'h21);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs transactions and protocol violations on the falling edge.
  logic [7:0] wr_dirs[$], wr_dats[$], tv_dat[$];
  logic [2:0] tv_idx[$];
  int rd_rise[$];
  int ack_cnt = 0, both_cnt = 0, gap_err = 0, stab_err = 0, lat_err = 0;
  int ack_cyc = 0, last_wdone = 0, last_rdone = 0, wr_low = 0, rd_low = 0;
  logic p_wr_go = 1'b0, p_rd_go = 1'b0, wr_first = 1'b1, rd_first = 1'b1;
  logic [7:0] p_wr_dir = 8'h00, p_wr_dato = 8'h00, p_rd_dir = 8'h00;
  always @(negedge clk) begin
    if (wr_go && rd_go) both_cnt++;
    if (wr_go && !p_wr_go) begin
      wr_dirs.push_back(wr_dir); wr_dats.push_back(wr_dato);
      if (!wr_first && wr_low != 1) gap_err++;
      $display("[%0d] write dir=%0h data=%0h", cyc, wr_dir, wr_dato);
    end
    if (rd_go && !p_rd_go) begin
      rd_rise.push_back(cyc);
      if (!rd_first && rd_low != 1) gap_err++;
    end
    if (wr_go && p_wr_go && (wr_dir != p_wr_dir || wr_dato != p_wr_dato)) stab_err++;
    if (rd_go && p_rd_go && rd_dir != p_rd_dir) stab_err++;
    wr_low = wr_go ? 0 : wr_low + 1;
    rd_low = rd_go ? 0 : rd_low + 1;
    if (wr_go) wr_first = 1'b0;
    if (rd_go) rd_first = 1'b0;
    if (!busy) begin wr_first = 1'b1; rd_first = 1'b1; end
    if (wr_done) last_wdone = cyc;
    if (rd_done) last_rdone = cyc;
    if (wr_ack) begin
      ack_cnt++; ack_cyc = cyc;
      if (cyc - last_wdone != 1) lat_err++;
      $display("[%0d] wr_ack", cyc);
    end
    if (t_valid) begin
      tv_idx.push_back(t_idx); tv_dat.push_back(t_data);
      if (cyc - last_rdone != 1) lat_err++;
      $display("[%0d] read idx=%0d data=%0h", cyc, t_idx, t_data);
    end
    p_wr_go = wr_go; p_rd_go = rd_go;
    p_wr_dir = wr_dir; p_wr_dato = wr_dato; p_rd_dir = rd_dir;
  end

  int n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic wait_acks(input int target, input int bound);
    int n = 0;
    while (ack_cnt < target && n < bound) begin @(negedge clk); n++; end
    check("wait_ack", 32'(ack_cnt >= target), 32'd1);
  endtask

  task automatic wait_reads(input int target, input int bound);
    int n = 0;
    while (tv_idx.size() < target && n < bound) begin @(negedge clk); n++; end
    check("wait_reads", 32'(tv_idx.size() >= target), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_count"}, 32'(wr_dirs.size() - base), 32'd6);
    for (int i = 0; i < 6 && base + i < wr_dirs.size(); i++) begin
      check({tag, "_dir"}, 32'(wr_dirs[base+i]), 32'(8'h21 + i));
      check({tag, "_dat"}, 32'(wr_dats[base+i]), 32'(8'h10 + i));
    end
  endtask

  task automatic check_reads(input string tag, input int base);
    check({tag, "_count"}, 32'(tv_idx.size() - base), 32'd6);
    for (int i = 0; i < 6 && base + i < tv_idx.size(); i++) begin
      check({tag, "_idx"}, 32'(tv_idx[base+i]), 32'(i));
      check({tag, "_dat"}, 32'(tv_dat[base+i]), 32'(8'h30 + i));
    end
  endtask

  initial begin
    int ab, wb, tb, rb, n;
    // Reset, including tick/wr_req asserted while reset is low.
    repeat (2) @(negedge clk);
    tick = 1'b1; wr_req = 1'b1;
    @(negedge clk);
    tick = 1'b0; wr_req = 1'b0;
    check("rst_wr_go", 32'(wr_go), 32'd0);
    check("rst_rd_go", 32'(rd_go), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wr_dir", 32'(wr_dir), 32'd0);
    check("rst_outs", 32'({wr_ack, t_valid, wr_idx, t_idx, t_data}), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_override", 32'(busy), 32'd0);

    // Write sequence.
    ab = ack_cnt; wb = wr_dirs.size();
    wr_req = 1'b1; @(negedge clk); wr_req = 1'b0;
    check("wr_latency", 32'(wr_go), 32'd1);
    wait_acks(ab + 1, 200);
    repeat (10) @(negedge clk);
    check("wr_acks", 32'(ack_cnt - ab), 32'd1);
    check_writes("wr", wb);
    check("wr_busy_after", 32'(busy), 32'd0);

    // Poll sequence.
    tb = tv_idx.size();
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    check("rd_latency", 32'(rd_go), 32'd1);
    wait_reads(tb + 6, 200);
    repeat (5) @(negedge clk);
    check_reads("rd", tb);
    check("rd_busy_after", 32'(busy), 32'd0);

    // Collision: write wins, extra ticks collapse into one read.
    ab = ack_cnt; wb = wr_dirs.size(); tb = tv_idx.size(); rb = rd_rise.size();
    tick = 1'b1; wr_req = 1'b1; @(negedge clk); tick = 1'b0; wr_req = 1'b0;
    check("coll_wr_first", 32'({wr_go, rd_go}), 32'b10);
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(negedge clk);
      tick = 1'b1; @(negedge clk); tick = 1'b0;
    end
    wait_reads(tb + 6, 400);
    repeat (40) @(negedge clk);
    check("coll_acks", 32'(ack_cnt - ab), 32'd1);
    check_writes("coll_wr", wb);
    check_reads("coll_rd", tb);
    check("coll_one_read_seq", 32'(rd_rise.size() - rb), 32'd6);
    if (rd_rise.size() > rb) check("coll_order", 32'(rd_rise[rb] > ack_cyc), 32'd1);

    // Held request re-arms only after a low sample.
    ab = ack_cnt; wb = wr_dirs.size();
    wr_req = 1'b1;
    wait_acks(ab + 1, 200);
    repeat (60) @(negedge clk);
    check("held_acks", 32'(ack_cnt - ab), 32'd1);
    check("held_writes", 32'(wr_dirs.size() - wb), 32'd6);
    check("held_busy", 32'(busy), 32'd0);
    wr_req = 1'b0; @(negedge clk);
    wr_req = 1'b1; @(negedge clk);
    check("rearm_go", 32'(wr_go), 32'd1);
    wr_req = 1'b0;
    wait_acks(ab + 2, 200);
    repeat (5) @(negedge clk);
    check("rearm_acks", 32'(ack_cnt - ab), 32'd2);

    // Reset in the middle of a read at idx 2.
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    n = 0;
    while (!(rd_go && rd_dir == 8'h23) && n < 100) begin @(negedge clk); n++; end
    check("rst_mid_reached", 32'(rd_dir), 32'h23);
    tb = tv_idx.size();
    reset = 1'b0; @(negedge clk);
    check("rst_mid_rd_go", 32'(rd_go), 32'd0);
    check("rst_mid_outs", 32'({busy, t_valid, wr_go, rd_dir}), 32'd0);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("rst_mid_no_tv", 32'(tv_idx.size() - tb), 32'd0);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    wait_reads(tb + 6, 200);
    repeat (5) @(negedge clk);
    check_reads("restart", tb);

`ifdef RTC_SCHED_TIMEOUT_EN
    // Watchdog: write engine silent on idx 1.
    silent_dir = 8'h22;
    ab = ack_cnt; wb = wr_dirs.size();
    wr_req = 1'b1; @(negedge clk); wr_req = 1'b0;
    n = 0;
    while (!(wr_go && wr_dir == 8'h22) && n < 100) begin @(negedge clk); n++; end
    repeat (19) @(negedge clk);
    check("to_err_cycle20", 32'(err), 32'd0);
    @(negedge clk);
    check("to_err_cycle21", 32'(err), 32'd1);
    wait_acks(ab + 1, 300);
    repeat (5) @(negedge clk);
    check_writes("to_wr", wb);
    check("to_err_sticky", 32'(err), 32'd1);
    silent_dir = 8'h00;
`endif

    check("never_both_go", 32'(both_cnt), 32'd0);
    check("gap_one_cycle", 32'(gap_err), 32'd0);
    check("go_stable", 32'(stab_err), 32'd0);
    check("ack_tv_latency", 32'(lat_err), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
